// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier arbiter: datapath width, FSM states and
// the latched operand pair.
package mult_pkg;
  localparam int DATA_WIDTH = 64;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;
  } mul_req_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting bit at or above the pointer,
// wrapping around to bit 0.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         i_req,
  input  logic [$clog2(NUM_REQ)-1:0] i_ptr,
  output logic [NUM_REQ-1:0]         o_gnt,
  output logic [$clog2(NUM_REQ)-1:0] o_gnt_idx
);
  localparam int IW = $clog2(NUM_REQ);

  logic w_found;
  int   w_idx;

  always_comb begin
    o_gnt     = '0;
    o_gnt_idx = '0;
    w_found   = 1'b0;
    w_idx     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_idx = (int'(i_ptr) + i) % NUM_REQ;
      if (!w_found && i_req[w_idx]) begin
        w_found          = 1'b1;
        o_gnt[w_idx]     = 1'b1;
        o_gnt_idx        = IW'(w_idx);
      end
    end
  end
endmodule

// File: rtl/mult_arbiter.sv
// Shares one iterative multiplier among NUM_REQ requesters: round-robin accept,
// enable/ready sequencing with a watchdog, and a one-cycle response to the owner.
module mult_arbiter
  import mult_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                              clk_i,
  input  logic                              rsn_i,
  input  logic [NUM_REQ-1:0]                req_valid_i,
  output logic [NUM_REQ-1:0]                req_ready_o,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op_a_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_op_b_i,
  output logic [NUM_REQ-1:0]                rsp_valid_o,
  output logic [DATA_WIDTH-1:0]             rsp_result_o,
  output logic                              rsp_error_o,
  output logic                              mul_enable_o,
  output logic [DATA_WIDTH-1:0]             mul_op_a_o,
  output logic [DATA_WIDTH-1:0]             mul_op_b_o,
  input  logic                              mul_ready_i,
  input  logic [DATA_WIDTH-1:0]             mul_result_i
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int WW = $clog2(TIMEOUT);
  localparam logic [WW-1:0]      WD_MAX = WW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE    = {{(NUM_REQ-1){1'b0}}, 1'b1};

  arb_state_t          r_state;
  mul_req_t            r_op;
  logic [IW-1:0]       r_gnt_idx;
  logic [IW-1:0]       r_ptr;
  logic [WW-1:0]       r_wd_cnt;
  logic [DATA_WIDTH-1:0] r_result;
  logic                r_mul_en;
  logic [NUM_REQ-1:0]  r_rsp_vld;
  logic                r_rsp_err;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [IW-1:0]       w_gnt_idx;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .i_req     (req_valid_i),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx)
  );

  // Ready is gated by reset so every output reads zero while reset is held.
  assign req_ready_o  = (rsn_i && r_state == IDLE) ? w_gnt : '0;
  assign mul_enable_o = r_mul_en;
  assign mul_op_a_o   = r_op.op_a;
  assign mul_op_b_o   = r_op.op_b;
  assign rsp_valid_o  = r_rsp_vld;
  assign rsp_error_o  = r_rsp_err;
  assign rsp_result_o = r_result;

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      r_state   <= IDLE;
      r_op      <= '0;
      r_gnt_idx <= '0;
      r_ptr     <= '0;
      r_wd_cnt  <= '0;
      r_result  <= '0;
      r_mul_en  <= 1'b0;
      r_rsp_vld <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|req_valid_i) begin
            r_op.op_a <= req_op_a_i[w_gnt_idx];
            r_op.op_b <= req_op_b_i[w_gnt_idx];
            r_gnt_idx <= w_gnt_idx;
            r_mul_en  <= 1'b1;
            r_state   <= ISSUE;
          end
        end
        ISSUE: begin
          r_mul_en <= 1'b0;
          r_wd_cnt <= '0;
          r_state  <= WAIT;
        end
        WAIT: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          // A completion in the last watchdog cycle still counts as a success.
          if (mul_ready_i) begin
            r_result  <= mul_result_i;
            r_rsp_err <= 1'b0;
            r_rsp_vld <= ONE << r_gnt_idx;
            r_state   <= RESP;
          end else if (r_wd_cnt == WD_MAX) begin
            r_result  <= '0;
            r_rsp_err <= 1'b1;
            r_rsp_vld <= ONE << r_gnt_idx;
            r_state   <= RESP;
          end
        end
        RESP: begin
          r_rsp_vld <= '0;
          r_rsp_err <= 1'b0;
          r_ptr     <= (r_gnt_idx == IW'(NUM_REQ - 1)) ? '0 : r_gnt_idx + 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural multiplier of programmable latency.
module tb_mult_arbiter;
  localparam int N  = 4;
  localparam int TO = 4;
  localparam int DW = mult_pkg::DATA_WIDTH;
  typedef logic [DW-1:0] word_t;
  typedef struct { int idx; word_t res; logic err; } exp_t;
  typedef int ord_t [8];

  logic                  clk;
  logic                  rsn_i;
  logic [N-1:0]          req_valid_i;
  logic [N-1:0]          req_ready_o;
  logic [N-1:0][DW-1:0]  req_op_a_i;
  logic [N-1:0][DW-1:0]  req_op_b_i;
  logic [N-1:0]          rsp_valid_o;
  word_t                 rsp_result_o;
  logic                  rsp_error_o;
  logic                  mul_enable_o;
  word_t                 mul_op_a_o;
  word_t                 mul_op_b_o;
  logic                  mul_ready_i;
  word_t                 mul_result_i;

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    rsp_count = 0;
  int    rsp_cyc = -1;
  int    en_cyc = -1;
  int    mdl_delay = 1;
  int    spur_req = 0;
  exp_t  sb[$];
  word_t exp_p [N] = '{64'd15, 64'd28, 64'd45, 64'd66};

  mult_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rsn_i(rsn_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_op_a_i(req_op_a_i), .req_op_b_i(req_op_b_i),
    .rsp_valid_o(rsp_valid_o), .rsp_result_o(rsp_result_o), .rsp_error_o(rsp_error_o),
    .mul_enable_o(mul_enable_o), .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
    .mul_ready_i(mul_ready_i), .mul_result_i(mul_result_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input word_t act, input word_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  // Multiplier model: pulses ready mdl_delay cycles after seeing enable (0 = never).
  initial begin
    int    cnt = 0;
    int    sd  = 0;
    word_t p   = '0;
    mul_ready_i  = 1'b0;
    mul_result_i = '0;
    forever begin
      tick();
      mul_ready_i  = 1'b0;
      mul_result_i = '0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin mul_ready_i = 1'b1; mul_result_i = p; end
      end
      if (spur_req != sd) begin
        sd = spur_req;
        mul_ready_i  = 1'b1;
        mul_result_i = 64'hDEAD_BEEF;
      end
      if (mul_enable_o && mdl_delay > 0) begin
        cnt = mdl_delay;
        p   = mul_op_a_o * mul_op_b_o;
      end
    end
  end

  // Monitor: pops the scoreboard whenever a response is presented.
  initial begin
    forever begin
      @(negedge clk);
      if (mul_enable_o) en_cyc = cyc;
      if (!$onehot0(req_ready_o)) begin
        checks++; errors++;
        $display("FAIL ready_onehot actual=%b required=onehot0", req_ready_o);
      end
      if (rsp_valid_o != '0) begin
        rsp_count++;
        rsp_cyc = cyc;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual=%b required=none", rsp_valid_o);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_owner", word_t'(rsp_valid_o), word_t'(1) << e.idx);
          chk("rsp_result", rsp_result_o, e.res);
          chk("rsp_error", word_t'(rsp_error_o), word_t'(e.err));
        end
      end
    end
  end

  task automatic set_ops();
    for (int k = 0; k < N; k++) begin
      req_op_a_i[k] = word_t'(k + 3);
      req_op_b_i[k] = word_t'(2 * k + 5);
    end
  endtask

  task automatic do_op(input int idx, input word_t a, input word_t b, input word_t er,
                       input logic ee, input int lat, input string nm);
    int t  = -1;
    int rc = 0;
    sb.push_back('{idx, er, ee});
    tick();
    req_op_a_i[idx]  = a;
    req_op_b_i[idx]  = b;
    req_valid_i[idx] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      settle();
      if (req_ready_o[idx]) begin t = cyc; break; end
    end
    if (t < 0) begin
      checks++; errors++;
      $display("FAIL %s_accept actual=none required=ready[%0d]", nm, idx);
      sb.delete();
      req_valid_i[idx] = 1'b0;
      return;
    end
    chk({nm, "_ready"}, word_t'(req_ready_o), word_t'(1) << idx);
    rc = rsp_count;
    tick();
    req_valid_i[idx] = 1'b0;
    for (int i = 0; i < 50 && rsp_count == rc; i++) settle();
    chk({nm, "_en_cyc"}, word_t'(en_cyc), word_t'(t + 1));
    chk({nm, "_rsp_cyc"}, word_t'(rsp_cyc), word_t'(t + lat));
  endtask

  // Holds the mask valid until n responses have come back in the given order.
  task automatic run_set(input logic [N-1:0] mask, input int n, input ord_t ord, input string nm);
    int rc;
    set_ops();
    for (int i = 0; i < n; i++) sb.push_back('{ord[i], exp_p[ord[i]], 1'b0});
    rc = rsp_count;
    tick();
    req_valid_i = mask;
    for (int i = 0; i < 200 && rsp_count < rc + n; i++) settle();
    tick();
    req_valid_i = '0;
    chk({nm, "_count"}, word_t'(rsp_count - rc), word_t'(n));
    if (sb.size() != 0) sb.delete();
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ready"}, word_t'(req_ready_o), '0);
    chk({nm, "_rsp_vld"}, word_t'(rsp_valid_o), '0);
    chk({nm, "_rsp_err"}, word_t'(rsp_error_o), '0);
    chk({nm, "_mul_en"}, word_t'(mul_enable_o), '0);
    chk({nm, "_op_a"}, mul_op_a_o, '0);
    chk({nm, "_op_b"}, mul_op_b_o, '0);
    chk({nm, "_result"}, rsp_result_o, '0);
  endtask

  initial begin
    int rc;
    int t;
    rsn_i       = 1'b0;
    req_valid_i = '0;
    set_ops();
    repeat (2) @(posedge clk);
    #1;
    req_valid_i = '1;
    #1;
    chk_zero("reset");
    req_valid_i = '0;
    tick(); rsn_i = 1'b1;
    tick(); tick();
    chk_zero("post_reset");

    mdl_delay = 1;
    run_set(4'hF, 5, '{0, 1, 2, 3, 0, 0, 0, 0}, "fair");
    do_op(0, 64'd3, 64'd5, 64'd15, 1'b0, 3, "single");
    do_op(3, 64'd6, 64'd11, 64'd66, 1'b0, 3, "req3");
    run_set(4'b0110, 2, '{1, 2, 0, 0, 0, 0, 0, 0}, "wrap");
    run_set(4'b0011, 2, '{0, 1, 0, 0, 0, 0, 0, 0}, "wrap_low");
    do_op(2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 3, "trunc");

    mdl_delay = 0;
    do_op(1, 64'd7, 64'd8, 64'd0, 1'b1, 2 + TO, "timeout");
    mdl_delay = 1;
    do_op(1, 64'd9, 64'd9, 64'd81, 1'b0, 3, "after_to");
    mdl_delay = 4;
    do_op(3, 64'd10, 64'd11, 64'd110, 1'b0, 6, "coincide");
    mdl_delay = 3;
    do_op(0, 64'd2, 64'd21, 64'd42, 1'b0, 5, "late_ready");

    mdl_delay = 1;
    rc = rsp_count;
    spur_req++;
    repeat (4) tick();
    chk("spur_no_rsp", word_t'(rsp_count - rc), '0);
    chk("spur_result_held", rsp_result_o, 64'd42);
    chk("spur_no_enable", word_t'(mul_enable_o), '0);
    do_op(1, 64'd6, 64'd8, 64'd48, 1'b0, 3, "post_spur");

    // Reset while the multiplier is still busy; its ready lands after release.
    mdl_delay = 3;
    t = -1;
    tick();
    req_op_a_i[2] = 64'd5; req_op_b_i[2] = 64'd5;
    req_valid_i[2] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      settle();
      if (req_ready_o[2]) begin t = cyc; break; end
    end
    chk("rst_accept", word_t'(t >= 0), 64'd1);
    tick(); req_valid_i[2] = 1'b0;
    tick(); rsn_i = 1'b0;
    #1;
    chk_zero("rst_mid");
    tick(); rsn_i = 1'b1;
    rc = rsp_count;
    repeat (6) tick();
    chk("rst_no_rsp", word_t'(rsp_count - rc), '0);
    mdl_delay = 1;
    run_set(4'b1001, 2, '{0, 3, 0, 0, 0, 0, 0, 0}, "rst_ptr");

    repeat (2) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end
endmodule

// File: doc/mult_arbiter.md
# mult_arbiter

Shares one iterative multiplier instance between `NUM_REQ` requesters. Requesters use a valid/ready handshake. The block selects one requester round-robin, sequences the multiplier's enable/ready protocol, and routes the result back to the granted requester. A watchdog guards against a multiplier that never completes. It sits between the core-side execution ports and the single `multiplier` datapath.

## Interface
- `DATA_WIDTH`, 64: operand and result width, taken from the shared package.
- `NUM_REQ`, 4: number of requesters, minimum 2.
- `TIMEOUT`, 16: maximum number of WAIT cycles before an error response, minimum 2.
- `clk_i`, in, 1: clock. Single clock domain.
- `rsn_i`, in, 1: reset. Asynchronous, active-low.
- `req_valid_i`, in, `NUM_REQ`: per-requester operation valid.
- `req_ready_o`, out, `NUM_REQ`: per-requester accept. One-hot or zero.
- `req_op_a_i`, in, `NUM_REQ`×`DATA_WIDTH`: operand A per requester.
- `req_op_b_i`, in, `NUM_REQ`×`DATA_WIDTH`: operand B per requester.
- `rsp_valid_o`, out, `NUM_REQ`: one-cycle response pulse to the owner. One-hot or zero.
- `rsp_result_o`, out, `DATA_WIDTH`: result. Low `DATA_WIDTH` bits of the product.
- `rsp_error_o`, out, 1: qualifies `rsp_valid_o`. 1 means timeout; `rsp_result_o` is then 0.
- `mul_enable_o`, out, 1: start pulse to the multiplier.
- `mul_op_a_o`, out, `DATA_WIDTH`: operand A to the multiplier.
- `mul_op_b_o`, out, `DATA_WIDTH`: operand B to the multiplier.
- `mul_ready_i`, in, 1: multiplier completion pulse.
- `mul_result_i`, in, `DATA_WIDTH`: multiplier result, valid while `mul_ready_i` is 1.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any `req_valid_i` bit is set, the round-robin winner `g` is chosen: first set bit at or above `rr_ptr`, wrapping.
  - `req_ready_o[g]`=1 in the same cycle. It is combinational from `req_valid_i` and is asserted only in IDLE.
  - On the clock edge: latch op_a/op_b of `g`, latch `g`, go to ISSUE.
- ISSUE:
  - `mul_enable_o`=1 for exactly one cycle.
  - `mul_op_a_o`/`mul_op_b_o` drive the latched operands. They stay stable through WAIT.
  - Clear `wd_cnt`, go to WAIT.
- WAIT:
  - `wd_cnt` increments each cycle.
  - On `mul_ready_i`=1: latch `mul_result_i`, set err=0, go to RESP.
  - Otherwise, when `wd_cnt`==`TIMEOUT`-1: set err=1, result=0, go to RESP.
  - If `mul_ready_i` and the timeout coincide, `mul_ready_i` wins and err=0.
- RESP:
  - `rsp_valid_o[g]`=1 and `rsp_error_o`=err for one cycle. There is no response backpressure.
  - `rr_ptr` ← (`g`+1) mod `NUM_REQ`. Go to IDLE.
- `mul_ready_i` outside WAIT is ignored. It does not change state, result or error.
- `rr_ptr` advances only on RESP, so a requester that waits is served within `NUM_REQ` transactions.
- A requester may re-assert `req_valid_i` in the cycle its response is issued. It is considered in the next IDLE cycle.
- The block applies no width arithmetic: the result is passed through unmodified.

## Timing
- Reset values:
  - `req_ready_o`, `rsp_valid_o`, `rsp_error_o`, `mul_enable_o` are 0.
  - `mul_op_a_o`, `mul_op_b_o`, `rsp_result_o` are 0.
  - `rr_ptr`=0, state=IDLE, `wd_cnt`=0.
- Reset mid-operation: the in-flight operation is dropped and no response is issued. A late `mul_ready_i` after reset is ignored.
- Nominal latency, with the multiplier pulsing ready one cycle after enable:
  - accept at cycle T;
  - `mul_enable_o` at T+1;
  - `mul_ready_i` at T+2;
  - `rsp_valid_o` at T+3;
  - next accept at T+4 at the earliest.
- Throughput is one operation per 4 cycles.
- Timeout response: `rsp_valid_o` with error at T+2+`TIMEOUT`.
- `rsp_result_o` holds its value until the next RESP. It is valid only when qualified by `rsp_valid_o`.

## Structure
- `mult_pkg`, shared package:
  - `DATA_WIDTH` localparam;
  - the `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP};
  - a `mul_req_t` struct (op_a, op_b).
- Sub-module `rr_arbiter`: combinational.
  - Inputs: req vector, `rr_ptr`.
  - Outputs: one-hot grant and grant index.
  - Parameterised on `NUM_REQ`.
- The top level holds the FSM, operand/result registers, `rr_ptr` and `wd_cnt` (width `$clog2(TIMEOUT)`).

## Test plan
- Single op: req 0 only, a=3, b=5 → `req_ready_o`=0001 at T, `mul_enable_o` at T+1, `rsp_valid_o`=0001 with result 15 and error 0 at T+3.
- Fairness: all 4 valid continuously from reset → grant order 0,1,2,3,0; each response is one-hot to the matching requester.
- Wrap: after requester 3 is served, only req 1 and req 2 valid → req 1 is granted first, then req 2.
- Timeout: `TIMEOUT`=4 and the model never asserts ready → `rsp_valid_o` with `rsp_error_o`=1 and result 0 at T+6; the next request is then served normally.
- Spurious/coincident ready: `mul_ready_i` pulsed in IDLE → no state change. Ready arriving in the final timeout cycle → err=0 with the correct product.
- Reset mid-WAIT: assert `rsn_i`=0 in WAIT → all outputs are 0 immediately; after release the late `mul_ready_i` is ignored and `rr_ptr` restarts at 0.
